// File: rtl/oled_pkg.sv
// Shared encodings for the OLED SPI byte writer: FSM states, D/C levels, SCLK phase count.
package oled_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    localparam logic OLED_CMD  = 1'b0;
    localparam logic OLED_DATA = 1'b1;

    localparam int SPI_PHASES = 16;
    localparam int PHASE_W    = $clog2(SPI_PHASES);

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } oled_req_t;

endpackage

// File: rtl/oled_spi_tick.sv
// SCLK half-period divider: pulses o_phase_end on the last clk of each CLK_DIV-cycle phase.
module oled_spi_tick #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_phase_end
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // With CLK_DIV=1 the counter sits at 0 and every cycle ends a phase.
    always_ff @(posedge clk) begin
        if (rst || i_clear || o_phase_end)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign o_phase_end = (r_cnt == TERM);

endmodule

// File: rtl/oled_spi_writer.sv
// Serialises one OLED command/data byte per request onto SPI mode 0, MSB first,
// with a one-entry pending slot for requests that arrive mid-transfer.
import oled_pkg::*;

module oled_spi_writer #(
    parameter int CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena_write,
    input  logic [7:0] data,
    input  logic       oled_dc,
    output logic       write_done,
    output logic       busy,
    output logic       overrun,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs,
    output logic       spi_dc
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SPI_PHASES - 1);

    state_t             r_state, w_nxt_state;
    logic [PHASE_W-1:0] r_phase, w_nxt_phase;
    logic               w_phase_end;
    logic               w_tick_clear;
    logic               w_load;
    oled_req_t          w_load_req;
    oled_req_t          w_in_req;
    logic               w_shift;
    logic               w_pend_wr;
    logic               w_pend_rd;
    logic               w_drop;

    oled_req_t          r_pend;
    logic               r_pend_full;
    logic [7:0]         r_shift;
    logic               r_cs;
    logic               r_sclk;
    logic               r_dc;
    logic               r_done;
    logic               r_busy;
    logic               r_ovr;

    assign w_in_req     = '{dc: oled_dc, data: data};
    assign w_tick_clear = (r_state == IDLE) || (r_state == DONE);

    oled_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_tick_clear),
        .o_phase_end (w_phase_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_phase <= w_nxt_phase;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_phase = r_phase;
        w_load      = 1'b0;
        w_load_req  = w_in_req;
        w_shift     = 1'b0;
        w_pend_wr   = 1'b0;
        w_pend_rd   = 1'b0;
        w_drop      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (ena_write) begin
                    w_nxt_state = SETUP;
                    w_load      = 1'b1;
                end
            end
            SETUP, SHIFT: begin
                if (ena_write) begin
                    if (r_pend_full) w_drop    = 1'b1;
                    else             w_pend_wr = 1'b1;
                end
                if (w_phase_end) begin
                    if (r_state == SETUP) begin
                        w_nxt_state = SHIFT;
                        w_nxt_phase = '0;
                    end else if (r_phase == LAST_PHASE) begin
                        w_nxt_state = DONE;
                    end else begin
                        // Even phases are SCLK-high; leaving one advances MOSI.
                        w_nxt_phase = r_phase + PHASE_W'(1);
                        w_shift     = ~r_phase[0];
                    end
                end
            end
            DONE: begin
                if (r_pend_full) begin
                    w_nxt_state = SETUP;
                    w_load      = 1'b1;
                    w_load_req  = r_pend;
                    w_pend_rd   = 1'b1;
                    w_pend_wr   = ena_write;
                end else if (ena_write) begin
                    w_nxt_state = SETUP;
                    w_load      = 1'b1;
                end else begin
                    w_nxt_state = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_full <= 1'b0;
        end else if (w_pend_wr) begin
            r_pend      <= w_in_req;
            r_pend_full <= 1'b1;
        end else if (w_pend_rd) begin
            r_pend_full <= 1'b0;
        end
    end

    // Link pins are decoded from the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs    <= 1'b1;
            r_sclk  <= 1'b0;
            r_shift <= '0;
            r_dc    <= OLED_DATA;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_cs   <= !((w_nxt_state == SETUP) || (w_nxt_state == SHIFT));
            r_sclk <= (w_nxt_state == SHIFT) && !w_nxt_phase[0];
            r_done <= (w_nxt_state == DONE);
            r_busy <= (r_state == SETUP) || (r_state == SHIFT);
            if (w_drop)
                r_ovr <= 1'b1;
            if (w_load) begin
                r_shift <= w_load_req.data;
                r_dc    <= w_load_req.dc;
            end else if (w_shift) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end
        end
    end

    assign spi_cs     = r_cs;
    assign spi_sclk   = r_sclk;
    assign spi_mosi   = r_shift[7];
    assign spi_dc     = r_dc;
    assign write_done = r_done;
    assign busy       = r_busy;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_oled_spi_writer.sv
// Bench for oled_spi_writer: CLK_DIV=1 and CLK_DIV=4 instances share stimulus and are
// checked per cycle against a transaction-level timing model plus an SPI wire decoder.
module tb_oled_spi_writer;
    import oled_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena_write = 1'b0;
    logic       oled_dc = 1'b0;
    logic [7:0] data = 8'h00;

    wire [1:0] w_done, w_busy, w_ovr, w_sclk, w_mosi, w_cs, w_dc;

    always #5 clk = ~clk;

    oled_spi_writer #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .ena_write(ena_write), .data(data), .oled_dc(oled_dc),
        .write_done(w_done[0]), .busy(w_busy[0]), .overrun(w_ovr[0]),
        .spi_sclk(w_sclk[0]), .spi_mosi(w_mosi[0]), .spi_cs(w_cs[0]), .spi_dc(w_dc[0])
    );

    oled_spi_writer #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .ena_write(ena_write), .data(data), .oled_dc(oled_dc),
        .write_done(w_done[1]), .busy(w_busy[1]), .overrun(w_ovr[1]),
        .spi_sclk(w_sclk[1]), .spi_mosi(w_mosi[1]), .spi_cs(w_cs[1]), .spi_dc(w_dc[1])
    );

    // A byte accepted at edge s occupies the engine until edge s+17*D+1, where the
    // DONE state is sampled and the next byte may start.
    typedef struct {
        bit         active;
        int         start;
        int         end_e;
        bit         qv;
        logic [8:0] q;
        bit         ovr;
    } model_t;

    typedef struct {
        logic [7:0] d;
        logic       dc;
        int         cyc1;
        int         cyc4;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         k = 0;
    int         DIV[2];
    model_t     m[2];
    logic [8:0] exp_b[2][256];
    int         exp_n[2];
    logic [8:0] obs_b[2][256];
    int         obs_n[2];

    bit         p_cs[2], p_sclk[2], p_mosi[2];
    logic [7:0] sh[2];
    logic       dc0[2];
    int         nb[2], hi_run[2], last_gap[2], done_cnt[2], last_rise[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_start(input int i, input int kk, input logic [8:0] v);
        m[i].active = 1'b1;
        m[i].start  = kk;
        m[i].end_e  = kk + 17 * DIV[i] + 1;
        if (exp_n[i] < 256) begin
            exp_b[i][exp_n[i]] = v;
            exp_n[i]++;
        end
    endtask

    task automatic model_step(input int i, input int kk);
        logic [8:0] req;
        req = {oled_dc, data};
        if (rst) begin
            if (m[i].active && kk < m[i].end_e && exp_n[i] > 0) exp_n[i]--;
            m[i] = '{default: 0};
        end else if (!m[i].active) begin
            if (ena_write) model_start(i, kk, req);
        end else if (kk < m[i].end_e) begin
            if (ena_write) begin
                if (!m[i].qv) begin
                    m[i].qv = 1'b1;
                    m[i].q  = req;
                end else begin
                    m[i].ovr = 1'b1;
                end
            end
        end else begin
            if (m[i].qv) begin
                model_start(i, kk, m[i].q);
                m[i].qv = ena_write;
                if (ena_write) m[i].q = req;
            end else if (ena_write) begin
                model_start(i, kk, req);
            end else begin
                m[i].active = 1'b0;
            end
        end
    endtask

    task automatic check_cycle(input int i);
        int  kk;
        bit  e_done, e_cs, e_busy;
        kk     = k - 1;
        e_done = m[i].active && (kk == m[i].end_e - 1);
        e_cs   = !(m[i].active && (kk <= m[i].end_e - 2));
        e_busy = m[i].active && (kk >= m[i].start + 1) && (kk <= m[i].end_e - 1);
        chk($sformatf("write_done[%0d]@%0d", i, kk), 32'(w_done[i]), 32'(e_done));
        chk($sformatf("spi_cs[%0d]@%0d", i, kk), 32'(w_cs[i]), 32'(e_cs));
        chk($sformatf("busy[%0d]@%0d", i, kk), 32'(w_busy[i]), 32'(e_busy));
        chk($sformatf("overrun[%0d]@%0d", i, kk), 32'(w_ovr[i]), 32'(m[i].ovr));
    endtask

    task automatic monitor(input int i);
        int kk;
        kk = k - 1;
        if (!w_cs[i]) begin
            if (p_cs[i]) begin
                nb[i]       = 0;
                sh[i]       = 8'h00;
                dc0[i]      = w_dc[i];
                last_gap[i] = hi_run[i];
                hi_run[i]   = 0;
            end else begin
                chk($sformatf("dc_stable[%0d]@%0d", i, kk), 32'(w_dc[i]), 32'(dc0[i]));
            end
            if (w_sclk[i] && !p_sclk[i]) begin
                if (nb[i] > 0)
                    chk($sformatf("sclk_period[%0d]@%0d", i, kk), 32'(kk - last_rise[i]), 32'(2 * DIV[i]));
                last_rise[i] = kk;
                sh[i] = {sh[i][6:0], w_mosi[i]};
                nb[i]++;
            end else if (w_sclk[i] && p_sclk[i]) begin
                chk($sformatf("mosi_hold[%0d]@%0d", i, kk), 32'(w_mosi[i]), 32'(p_mosi[i]));
            end
        end else begin
            hi_run[i]++;
            chk($sformatf("sclk_idle[%0d]@%0d", i, kk), 32'(w_sclk[i]), 32'(0));
            if (!p_cs[i] && w_done[i] && nb[i] == 8 && obs_n[i] < 256) begin
                obs_b[i][obs_n[i]] = {dc0[i], sh[i]};
                obs_n[i]++;
            end
        end
        if (w_done[i]) done_cnt[i]++;
        p_cs[i]   = w_cs[i];
        p_sclk[i] = w_sclk[i];
        p_mosi[i] = w_mosi[i];
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, k);
        k++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_cycle(i);
            monitor(i);
        end
    endtask

    task automatic req(input logic [7:0] d, input logic dc);
        data      = d;
        oled_dc   = dc;
        ena_write = 1'b1;
        tick();
        ena_write = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m[0].active || m[0].qv || m[1].active || m[1].qv) && n < 400) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n >= 400), 32'(0));
        tick();
        tick();
    endtask

    task automatic check_bytes(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_count[%0d]", tag, i), 32'(obs_n[i]), 32'(exp_n[i]));
            for (int j = 0; j < obs_n[i] && j < exp_n[i]; j++)
                chk($sformatf("%s_byte[%0d][%0d]", tag, i, j), 32'(obs_b[i][j]), 32'(exp_b[i][j]));
            obs_n[i] = 0;
            exp_n[i] = 0;
            obs_b[i][0] = 9'bx;
            obs_b[i][1] = 9'bx;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        int   k0, n, dc_before;
        int   lat[2], busyc[2], csl[2];

        DIV[0] = 1;
        DIV[1] = 4;
        for (int i = 0; i < 2; i++) begin
            m[i] = '{default: 0};
            exp_n[i] = 0; obs_n[i] = 0;
            p_cs[i] = 1'b1; p_sclk[i] = 1'b0; p_mosi[i] = 1'b0;
            sh[i] = 8'h00; dc0[i] = 1'b1;
            nb[i] = 0; hi_run[i] = 0; last_gap[i] = 0; done_cnt[i] = 0; last_rise[i] = 0;
        end

        vt[0] = '{d: 8'hAE, dc: OLED_CMD,  cyc1: 17, cyc4: 68};
        vt[1] = '{d: 8'h00, dc: OLED_DATA, cyc1: 17, cyc4: 68};
        vt[2] = '{d: 8'hFF, dc: OLED_DATA, cyc1: 17, cyc4: 68};
        vt[3] = '{d: 8'h5A, dc: OLED_CMD,  cyc1: 17, cyc4: 68};
        vt[4] = '{d: 8'h81, dc: OLED_DATA, cyc1: 17, cyc4: 68};

        // Reset values
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_cs[%0d]", i),   32'(w_cs[i]),   32'(1));
            chk($sformatf("rst_sclk[%0d]", i), 32'(w_sclk[i]), 32'(0));
            chk($sformatf("rst_mosi[%0d]", i), 32'(w_mosi[i]), 32'(0));
            chk($sformatf("rst_dc[%0d]", i),   32'(w_dc[i]),   32'(1));
            chk($sformatf("rst_done[%0d]", i), 32'(w_done[i]), 32'(0));
            chk($sformatf("rst_busy[%0d]", i), 32'(w_busy[i]), 32'(0));
            chk($sformatf("rst_ovr[%0d]", i),  32'(w_ovr[i]),  32'(0));
        end
        rst = 1'b0;
        tick();

        // Single-byte vectors: latency, busy length, CS-low length, decoded byte
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 2; i++) begin
                lat[i] = -1; busyc[i] = 0; csl[i] = 0;
            end
            req(vt[v].d, vt[v].dc);
            k0 = k - 1;
            n  = 0;
            while (1) begin
                for (int i = 0; i < 2; i++) begin
                    if (lat[i] < 0) begin
                        if (!w_cs[i])  csl[i]++;
                        if (w_busy[i]) busyc[i]++;
                        if (w_done[i]) lat[i] = (k - 1) - k0;
                    end
                end
                if ((lat[0] >= 0 && lat[1] >= 0) || n >= 300) break;
                tick();
                n++;
            end
            chk($sformatf("v%0d_lat1", v),   32'(lat[0]),   32'(vt[v].cyc1));
            chk($sformatf("v%0d_lat4", v),   32'(lat[1]),   32'(vt[v].cyc4));
            chk($sformatf("v%0d_busy1", v),  32'(busyc[0]), 32'(vt[v].cyc1));
            chk($sformatf("v%0d_busy4", v),  32'(busyc[1]), 32'(vt[v].cyc4));
            chk($sformatf("v%0d_cslow1", v), 32'(csl[0]),   32'(vt[v].cyc1));
            chk($sformatf("v%0d_cslow4", v), 32'(csl[1]),   32'(vt[v].cyc4));
            wait_idle();
            chk($sformatf("v%0d_wire1", v), 32'(obs_b[0][0]), 32'({vt[v].dc, vt[v].d}));
            chk($sformatf("v%0d_wire4", v), 32'(obs_b[1][0]), 32'({vt[v].dc, vt[v].d}));
            check_bytes($sformatf("v%0d", v));
        end

        // Second request queued while the first shifts
        dc_before = done_cnt[0];
        req(8'h8D, OLED_CMD);
        repeat (2) tick();
        req(8'h14, OLED_CMD);
        wait_idle();
        chk("queue_gap1", 32'(last_gap[0]), 32'(1));
        chk("queue_gap4", 32'(last_gap[1]), 32'(1));
        chk("queue_dones", 32'(done_cnt[0] - dc_before), 32'(2));
        chk("queue_ovr", 32'(w_ovr[0]), 32'(0));
        chk("queue_b0", 32'(obs_b[0][0]), 32'({OLED_CMD, 8'h8D}));
        chk("queue_b1", 32'(obs_b[0][1]), 32'({OLED_CMD, 8'h14}));
        check_bytes("queue");

        // Third request with the slot full is dropped; overrun is sticky
        req(8'h8D, OLED_CMD);
        repeat (2) tick();
        req(8'h14, OLED_CMD);
        tick();
        req(8'hAF, OLED_CMD);
        wait_idle();
        chk("drop_ovr1", 32'(w_ovr[0]), 32'(1));
        chk("drop_ovr4", 32'(w_ovr[1]), 32'(1));
        chk("drop_count", 32'(obs_n[0]), 32'(2));
        chk("drop_b1", 32'(obs_b[0][1]), 32'({OLED_CMD, 8'h14}));
        check_bytes("drop");
        repeat (20) tick();
        chk("drop_sticky", 32'(w_ovr[0]), 32'(1));
        do_reset();
        chk("drop_rst_clear", 32'(w_ovr[0]), 32'(0));

        // Reset mid-byte aborts without write_done, then a clean byte follows
        dc_before = done_cnt[0];
        req(8'hF0, OLED_DATA);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_cs", 32'(w_cs[0]), 32'(1));
        chk("abort_sclk", 32'(w_sclk[0]), 32'(0));
        chk("abort_done", 32'(w_done[0]), 32'(0));
        wait_idle();
        chk("abort_no_done", 32'(done_cnt[0] - dc_before), 32'(0));
        check_bytes("abort");
        req(8'hFF, OLED_DATA);
        wait_idle();
        chk("after_abort", 32'(obs_b[0][0]), 32'({OLED_DATA, 8'hFF}));
        check_bytes("after_abort");

        // Request landing exactly in the DONE cycle starts the next byte at once
        req(8'hA5, OLED_CMD);
        repeat (17) tick();
        chk("done_cycle", 32'(w_done[0]), 32'(1));
        req(8'h3C, OLED_DATA);
        k0 = k - 1;
        n  = 0;
        while (!w_done[0] && n < 100) begin
            tick();
            n++;
        end
        chk("b2b_lat", 32'((k - 1) - k0), 32'(17));
        chk("b2b_gap", 32'(last_gap[0]), 32'(1));
        chk("b2b_ovr", 32'(w_ovr[0]), 32'(0));
        wait_idle();
        chk("b2b_b0", 32'(obs_b[0][0]), 32'({OLED_CMD, 8'hA5}));
        chk("b2b_b1", 32'(obs_b[0][1]), 32'({OLED_DATA, 8'h3C}));
        check_bytes("b2b");

        // Random traffic with occasional resets
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            ena_write = ($urandom_range(0, 7) == 0);
            data      = 8'($urandom);
            oled_dc   = 1'($urandom);
            tick();
        end
        rst       = 1'b0;
        ena_write = 1'b0;
        wait_idle();
        check_bytes("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
